// File: rtl/lsu_mem_ctrl_if.sv
// rtl/lsu_mem_ctrl_if.sv - doubleword data-memory request/response bus
interface lsu_mem_ctrl_if #(
  parameter int ADDR_WIDTH = 64
);
  logic                  out_mem_req;
  logic                  out_mem_we;
  logic [ADDR_WIDTH-1:0] out_mem_addr;
  logic [63:0]           out_mem_wdata;
  logic [7:0]            out_mem_wstrb;
  logic                  in_mem_ready;
  logic                  in_mem_rvalid;
  logic [63:0]           in_mem_rdata;

  // Load/store unit side: drives the request, receives ready and load data
  modport master (
    output out_mem_req, out_mem_we, out_mem_addr, out_mem_wdata, out_mem_wstrb,
    input  in_mem_ready, in_mem_rvalid, in_mem_rdata
  );

  // Memory side
  modport slave (
    input  out_mem_req, out_mem_we, out_mem_addr, out_mem_wdata, out_mem_wstrb,
    output in_mem_ready, in_mem_rvalid, in_mem_rdata
  );
endinterface

// File: rtl/lsu_mem_ctrl.sv
// rtl/lsu_mem_ctrl.sv - MEM-stage load/store unit driving a 64-bit data memory
module lsu_mem_ctrl #(
  parameter int          ADDR_WIDTH     = 64,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic                  Clk,
  input  logic                  Rst,
  input  logic                  in_req_valid,
  input  logic                  in_we,
  input  logic [1:0]            in_size,
  input  logic                  in_unsigned,
  input  logic [ADDR_WIDTH-1:0] in_addr,
  input  logic [63:0]           in_wr_data,
  output logic [63:0]           out_rd_data,
  output logic                  out_done,
  output logic                  out_err,
  output logic                  out_stall,
  lsu_mem_ctrl_if.master        mem
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [2:0]            off_q;
  logic [7:0]            wstrb_q;
  logic [63:0]           wdata_q;
  logic [1:0]            size_q;
  logic                  uns_q;
  logic                  we_q;
  logic                  err_q;
  logic [31:0]           cnt_q;
  logic [63:0]           rd_q;

  logic                  misaligned;
  logic [7:0]            size_mask;
  logic [63:0]           shifted;
  logic [63:0]           load_ext;
  logic                  timeout_hit;

  // Alignment check and byte-lane mask for the access presented in IDLE
  always_comb begin
    misaligned = 1'b0;
    size_mask  = 8'h01;
    case (in_size)
      2'b00: begin misaligned = 1'b0;            size_mask = 8'h01; end
      2'b01: begin misaligned = in_addr[0];      size_mask = 8'h03; end
      2'b10: begin misaligned = |in_addr[1:0];   size_mask = 8'h0F; end
      default: begin misaligned = |in_addr[2:0]; size_mask = 8'hFF; end
    endcase
  end

  // Right-align the returned doubleword and extend it to the access size
  always_comb begin
    shifted  = mem.in_mem_rdata >> {off_q, 3'b000};
    load_ext = shifted;
    case (size_q)
      2'b00:   load_ext = uns_q ? {56'd0, shifted[7:0]}  : {{56{shifted[7]}},  shifted[7:0]};
      2'b01:   load_ext = uns_q ? {48'd0, shifted[15:0]} : {{48{shifted[15]}}, shifted[15:0]};
      2'b10:   load_ext = uns_q ? {32'd0, shifted[31:0]} : {{32{shifted[31]}}, shifted[31:0]};
      default: load_ext = shifted;
    endcase
  end

  // A zero timeout setting means a load waits for rvalid forever
  assign timeout_hit = (TIMEOUT_CYCLES != 0) && (cnt_q == TIMEOUT_CYCLES - 1);

  // State register
  always_ff @(posedge Clk) begin
    if (Rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state and handshake outputs
  always_comb begin
    state_d         = state_q;
    out_stall       = 1'b0;
    out_done        = 1'b0;
    out_err         = 1'b0;
    mem.out_mem_req = 1'b0;
    case (state_q)
      IDLE: begin
        out_stall = in_req_valid;
        if (in_req_valid) state_d = misaligned ? DONE : REQ;
      end
      REQ: begin
        out_stall       = 1'b1;
        mem.out_mem_req = 1'b1;
        if (mem.in_mem_ready) state_d = we_q ? DONE : WAIT;
      end
      WAIT: begin
        out_stall = 1'b1;
        if (mem.in_mem_rvalid || timeout_hit) state_d = DONE;
      end
      default: begin
        out_done = 1'b1;
        out_err  = err_q;
        state_d  = IDLE;
      end
    endcase
  end

  // Access latch, wait counter, error flag and load result register
  always_ff @(posedge Clk) begin
    if (Rst) begin
      addr_q  <= '0;
      off_q   <= '0;
      wstrb_q <= '0;
      wdata_q <= '0;
      size_q  <= '0;
      uns_q   <= 1'b0;
      we_q    <= 1'b0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
      rd_q    <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_req_valid) begin
            addr_q  <= {in_addr[ADDR_WIDTH-1:3], 3'b000};
            off_q   <= in_addr[2:0];
            wstrb_q <= in_we ? (size_mask << in_addr[2:0]) : 8'h00;
            wdata_q <= in_wr_data << {in_addr[2:0], 3'b000};
            size_q  <= in_size;
            uns_q   <= in_unsigned;
            we_q    <= in_we;
            err_q   <= misaligned;
          end
        end
        REQ: begin
          if (mem.in_mem_ready && !we_q) cnt_q <= '0;
        end
        WAIT: begin
          if (mem.in_mem_rvalid) begin
            rd_q <= load_ext;
          end else begin
            cnt_q <= cnt_q + 32'd1;
            if (timeout_hit) err_q <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign out_rd_data       = rd_q;
  assign mem.out_mem_we    = we_q;
  assign mem.out_mem_addr  = addr_q;
  assign mem.out_mem_wdata = wdata_q;
  assign mem.out_mem_wstrb = wstrb_q;

endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// tb/tb_lsu_mem_ctrl.sv - vector table, corner sequences and random accesses against a reference model
module tb_lsu_mem_ctrl;
  localparam int AW = 64;
  localparam int TO = 4;

  logic          Clk = 1'b0;
  logic          Rst;
  logic          in_req_valid;
  logic          in_we;
  logic [1:0]    in_size;
  logic          in_unsigned;
  logic [AW-1:0] in_addr;
  logic [63:0]   in_wr_data;
  logic [63:0]   out_rd_data;
  logic          out_done;
  logic          out_err;
  logic          out_stall;

  lsu_mem_ctrl_if #(.ADDR_WIDTH(AW)) mif ();

  lsu_mem_ctrl #(.ADDR_WIDTH(AW), .TIMEOUT_CYCLES(TO)) dut (
    .Clk          (Clk),
    .Rst          (Rst),
    .in_req_valid (in_req_valid),
    .in_we        (in_we),
    .in_size      (in_size),
    .in_unsigned  (in_unsigned),
    .in_addr      (in_addr),
    .in_wr_data   (in_wr_data),
    .out_rd_data  (out_rd_data),
    .out_done     (out_done),
    .out_err      (out_err),
    .out_stall    (out_stall),
    .mem          (mif)
  );

  always #5 Clk = ~Clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Observations of one access
  int          obs_done_cyc;
  logic        obs_err;
  logic [63:0] obs_rd;
  int          obs_reqn;
  int          obs_unstable;
  int          obs_proto_bad;
  logic [63:0] cap_addr;
  logic [7:0]  cap_wstrb;
  logic [63:0] cap_wdata;
  logic        cap_we;

  logic [63:0] rd_model;

  typedef struct {
    bit          we;
    logic [1:0]  size;
    bit          uns;
    logic [63:0] addr;
    logic [63:0] wdata;
    logic [63:0] rdata;
    int          rdy;
    int          rv;
    bit          rv_acc;
    int          e_done;
    bit          e_err;
    logic [63:0] e_rd;
    int          e_reqn;
    logic [63:0] e_addr;
    logic [7:0]  e_strb;
    logic [63:0] e_wdata;
  } vec_t;

  vec_t tbl [14];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Present one access at the current negedge and play the memory side until out_done
  task automatic run_access(input bit we, input logic [1:0] size, input bit uns,
                            input logic [63:0] addr, input logic [63:0] wdata,
                            input logic [63:0] rdata, input int rdy, input int rv,
                            input bit rv_acc);
    int cyc;
    int widx;
    bit accepted;
    in_req_valid = 1'b1;
    in_we        = we;
    in_size      = size;
    in_unsigned  = uns;
    in_addr      = addr;
    in_wr_data   = wdata;
    obs_done_cyc  = -1;
    obs_err       = 1'b0;
    obs_rd        = '0;
    obs_reqn      = 0;
    obs_unstable  = 0;
    obs_proto_bad = 0;
    accepted      = 1'b0;
    widx          = 0;
    cyc           = 1;
    while (cyc <= 40) begin
      mif.in_mem_ready  = 1'b0;
      mif.in_mem_rvalid = 1'b0;
      mif.in_mem_rdata  = 64'hA5A5_5A5A_A5A5_5A5A;
      if (accepted) begin
        if (widx == rv) begin
          mif.in_mem_rvalid = 1'b1;
          mif.in_mem_rdata  = rdata;
        end
        widx++;
      end
      if (mif.out_mem_req) begin
        if (obs_reqn == 0) begin
          cap_addr  = mif.out_mem_addr;
          cap_wstrb = mif.out_mem_wstrb;
          cap_wdata = mif.out_mem_wdata;
          cap_we    = mif.out_mem_we;
        end else if (mif.out_mem_addr !== cap_addr || mif.out_mem_wstrb !== cap_wstrb ||
                     mif.out_mem_wdata !== cap_wdata || mif.out_mem_we !== cap_we) begin
          obs_unstable++;
        end
        if (obs_reqn == rdy) begin
          mif.in_mem_ready = 1'b1;
          accepted = 1'b1;
          if (rv_acc) begin
            mif.in_mem_rvalid = 1'b1;
            mif.in_mem_rdata  = ~rdata;
          end
        end
        obs_reqn++;
      end
      #1;
      if (out_done) begin
        obs_done_cyc = cyc;
        obs_err      = out_err;
        obs_rd       = out_rd_data;
        if (out_stall) obs_proto_bad++;
        break;
      end
      if (!out_stall || out_err) obs_proto_bad++;
      @(negedge Clk);
      cyc++;
    end
    in_req_valid      = 1'b0;
    mif.in_mem_ready  = 1'b0;
    mif.in_mem_rvalid = 1'b0;
    @(negedge Clk);
  endtask

  task automatic check_result(input string tag, input int e_done, input bit e_err,
                              input logic [63:0] e_rd, input int e_reqn,
                              input logic [63:0] e_addr, input logic [7:0] e_strb,
                              input logic [63:0] e_wdata, input bit e_we);
    chk({tag, ".done_cycle"}, 64'(obs_done_cyc), 64'(e_done));
    chk({tag, ".err"}, 64'(obs_err), 64'(e_err));
    chk({tag, ".rd_data"}, obs_rd, e_rd);
    chk({tag, ".req_cycles"}, 64'(obs_reqn), 64'(e_reqn));
    chk({tag, ".req_stable"}, 64'(obs_unstable), 64'd0);
    chk({tag, ".stall_err_shape"}, 64'(obs_proto_bad), 64'd0);
    if (e_reqn > 0) begin
      chk({tag, ".mem_addr"}, cap_addr, e_addr);
      chk({tag, ".wstrb"}, 64'(cap_wstrb), 64'(e_strb));
      chk({tag, ".wdata"}, cap_wdata, e_wdata);
      chk({tag, ".we"}, 64'(cap_we), 64'(e_we));
    end
  endtask

  initial begin
    int          e_done;
    bit          e_err;
    int          e_reqn;
    logic [63:0] e_addr;
    logic [7:0]  e_strb;
    logic [63:0] e_wdata;
    logic [63:0] val;
    logic [63:0] off;
    int          nbytes;
    bit          we, uns, rv_acc;
    logic [1:0]  size;
    logic [63:0] addr, wdata, rdata;
    int          rdy, rv;

    // we size uns addr wdata rdata rdy rv rv_acc | done err rd reqn maddr strb wdata
    tbl[0]  = '{1'b1, 2'd0, 1'b0, 64'h1005, 64'hAB, 64'h0, 0, 0, 1'b0,
                3, 1'b0, 64'h0, 1, 64'h1000, 8'h20, 64'h0000_AB00_0000_0000};
    tbl[1]  = '{1'b0, 2'd1, 1'b0, 64'h2006, 64'h0, 64'h8123_0000_0000_0000, 0, 1, 1'b0,
                5, 1'b0, 64'hFFFF_FFFF_FFFF_8123, 1, 64'h2000, 8'h00, 64'h0};
    tbl[2]  = '{1'b0, 2'd1, 1'b1, 64'h2006, 64'h0, 64'h8123_0000_0000_0000, 0, 1, 1'b0,
                5, 1'b0, 64'h0000_0000_0000_8123, 1, 64'h2000, 8'h00, 64'h0};
    tbl[3]  = '{1'b0, 2'd2, 1'b0, 64'h3002, 64'h0, 64'h0, 0, 0, 1'b0,
                2, 1'b1, 64'h0000_0000_0000_8123, 0, 64'h0, 8'h00, 64'h0};
    tbl[4]  = '{1'b1, 2'd3, 1'b0, 64'h4000, 64'h0123_4567_89AB_CDEF, 64'h0, 5, 0, 1'b0,
                8, 1'b0, 64'h0000_0000_0000_8123, 6, 64'h4000, 8'hFF, 64'h0123_4567_89AB_CDEF};
    tbl[5]  = '{1'b0, 2'd3, 1'b0, 64'h5000, 64'h0, 64'h1111_1111_1111_1111, 0, 9, 1'b0,
                7, 1'b1, 64'h0000_0000_0000_8123, 1, 64'h5000, 8'h00, 64'h0};
    tbl[6]  = '{1'b0, 2'd3, 1'b0, 64'h5008, 64'h0, 64'hDEAD_BEEF_CAFE_F00D, 0, 3, 1'b0,
                7, 1'b0, 64'hDEAD_BEEF_CAFE_F00D, 1, 64'h5008, 8'h00, 64'h0};
    tbl[7]  = '{1'b0, 2'd2, 1'b0, 64'h6004, 64'h0, 64'h89AB_CDEF_0000_0000, 0, 0, 1'b0,
                4, 1'b0, 64'hFFFF_FFFF_89AB_CDEF, 1, 64'h6000, 8'h00, 64'h0};
    tbl[8]  = '{1'b0, 2'd0, 1'b1, 64'h7003, 64'h0, 64'h0000_0000_F000_0000, 1, 0, 1'b0,
                5, 1'b0, 64'h0000_0000_0000_00F0, 2, 64'h7000, 8'h00, 64'h0};
    tbl[9]  = '{1'b1, 2'd1, 1'b0, 64'h1001, 64'h1234, 64'h0, 0, 0, 1'b0,
                2, 1'b1, 64'h0000_0000_0000_00F0, 0, 64'h0, 8'h00, 64'h0};
    tbl[10] = '{1'b1, 2'd1, 1'b0, 64'h0012, 64'hFFFF_0000_0000_BEEF, 64'h0, 0, 0, 1'b0,
                3, 1'b0, 64'h0000_0000_0000_00F0, 1, 64'h0010, 8'h0C, 64'h0000_0000_BEEF_0000};
    tbl[11] = '{1'b0, 2'd0, 1'b0, 64'h001F, 64'h0, 64'h8000_0000_0000_0000, 0, 2, 1'b1,
                6, 1'b0, 64'hFFFF_FFFF_FFFF_FF80, 1, 64'h0018, 8'h00, 64'h0};
    tbl[12] = '{1'b0, 2'd3, 1'b0, 64'h8000, 64'h0, 64'h0123_4567_89AB_CDEF, 0, 4, 1'b0,
                7, 1'b1, 64'hFFFF_FFFF_FFFF_FF80, 1, 64'h8000, 8'h00, 64'h0};
    tbl[13] = '{1'b1, 2'd2, 1'b0, 64'h9004, 64'h0000_0000_CAFE_BABE, 64'h0, 2, 0, 1'b0,
                5, 1'b0, 64'hFFFF_FFFF_FFFF_FF80, 3, 64'h9000, 8'hF0, 64'hCAFE_BABE_0000_0000};

    Rst               = 1'b1;
    in_req_valid      = 1'b0;
    in_we             = 1'b0;
    in_size           = 2'd0;
    in_unsigned       = 1'b0;
    in_addr           = '0;
    in_wr_data        = '0;
    mif.in_mem_ready  = 1'b0;
    mif.in_mem_rvalid = 1'b0;
    mif.in_mem_rdata  = '0;

    @(negedge Clk);
    @(negedge Clk);
    chk("reset.mem_req", 64'(mif.out_mem_req), 64'd0);
    chk("reset.stall", 64'(out_stall), 64'd0);
    chk("reset.done", 64'(out_done), 64'd0);
    chk("reset.err", 64'(out_err), 64'd0);
    chk("reset.rd_data", out_rd_data, 64'd0);
    chk("reset.wstrb", 64'(mif.out_mem_wstrb), 64'd0);
    chk("reset.mem_addr", mif.out_mem_addr, 64'd0);
    Rst = 1'b0;

    // Back-to-back table vectors
    for (int i = 0; i < 14; i++) begin
      run_access(tbl[i].we, tbl[i].size, tbl[i].uns, tbl[i].addr, tbl[i].wdata,
                 tbl[i].rdata, tbl[i].rdy, tbl[i].rv, tbl[i].rv_acc);
      check_result($sformatf("vec%0d", i), tbl[i].e_done, tbl[i].e_err, tbl[i].e_rd,
                   tbl[i].e_reqn, tbl[i].e_addr, tbl[i].e_strb, tbl[i].e_wdata, tbl[i].we);
    end

    // Reset in the middle of a load's WAIT phase, then a late response
    in_req_valid = 1'b1;
    in_we        = 1'b0;
    in_size      = 2'd3;
    in_unsigned  = 1'b0;
    in_addr      = 64'hA000;
    #1 chk("rstseq.idle_stall", 64'(out_stall), 64'd1);
    @(negedge Clk);
    chk("rstseq.req", 64'(mif.out_mem_req), 64'd1);
    mif.in_mem_ready = 1'b1;
    @(negedge Clk);
    mif.in_mem_ready = 1'b0;
    #1 chk("rstseq.wait_stall", 64'(out_stall), 64'd1);
    Rst          = 1'b1;
    in_req_valid = 1'b0;
    @(negedge Clk);
    #1;
    chk("rstseq.mem_req", 64'(mif.out_mem_req), 64'd0);
    chk("rstseq.stall", 64'(out_stall), 64'd0);
    chk("rstseq.rd_data", out_rd_data, 64'd0);
    chk("rstseq.done", 64'(out_done), 64'd0);
    @(negedge Clk);
    Rst               = 1'b0;
    mif.in_mem_rvalid = 1'b1;
    mif.in_mem_rdata  = 64'h5555_5555_5555_5555;
    @(negedge Clk);
    mif.in_mem_rvalid = 1'b0;
    #1;
    chk("rstseq.late_done", 64'(out_done), 64'd0);
    chk("rstseq.late_rd", out_rd_data, 64'd0);
    chk("rstseq.late_req", 64'(mif.out_mem_req), 64'd0);
    @(negedge Clk);
    rd_model = 64'd0;

    // Random accesses against the reference model
    for (int n = 0; n < 200; n++) begin
      size   = 2'($urandom_range(0, 3));
      we     = 1'($urandom_range(0, 1));
      uns    = 1'($urandom_range(0, 1));
      addr   = {$urandom, $urandom};
      nbytes = 1 << size;
      if ($urandom_range(0, 3) != 0) addr = addr - (addr % 64'(nbytes));
      wdata  = {$urandom, $urandom};
      rdata  = {$urandom, $urandom};
      rdy    = $urandom_range(0, 3);
      rv     = $urandom_range(0, 5);
      rv_acc = 1'($urandom_range(0, 1));

      off     = addr % 8;
      e_addr  = addr - off;
      e_strb  = 8'h00;
      e_wdata = wdata << (8 * off);
      if ((addr % 64'(nbytes)) != 0) begin
        e_done = 2;
        e_err  = 1'b1;
        e_reqn = 0;
      end else if (we) begin
        e_done = 3 + rdy;
        e_err  = 1'b0;
        e_reqn = rdy + 1;
        e_strb = 8'(((64'd1 << nbytes) - 64'd1) << off);
      end else begin
        e_reqn = rdy + 1;
        if (rv < TO) begin
          e_done = 4 + rdy + rv;
          e_err  = 1'b0;
          val    = rdata >> (8 * off);
          if (nbytes < 8) begin
            val = val % (64'd1 << (8 * nbytes));
            if (!uns && val >= (64'd1 << (8 * nbytes - 1))) val = val - (64'd1 << (8 * nbytes));
          end
          rd_model = val;
        end else begin
          e_done = 3 + rdy + TO;
          e_err  = 1'b1;
        end
      end

      run_access(we, size, uns, addr, wdata, rdata, rdy, rv, rv_acc);
      check_result($sformatf("rnd%0d", n), e_done, e_err, rd_model, e_reqn,
                   e_addr, e_strb, e_wdata, we);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
